// File: rtl/decode_iq.sv
// Instruction queue between fetch and decode: buffers {pc, instr} pairs, predecodes the
// head entry and holds it back while the exec-stage load would feed one of its sources.
module decode_iq #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [INSTR_W-1:0]         i_instr,
    input  logic [ADDR_W-1:0]          i_pc,
    input  logic                       i_flush,
    input  logic                       i_stall,
    input  logic                       i_ex_load,
    input  logic [4:0]                 i_ex_rd_no,
    output logic                       o_valid,
    output logic [INSTR_W-1:0]         o_instr,
    output logic [ADDR_W-1:0]          o_pc,
    output logic [4:0]                 o_rs_no,
    output logic [4:0]                 o_rt_no,
    output logic                       o_is_branch,
    output logic                       o_is_load,
    output logic                       o_hazard,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [ADDR_W+INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;

    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic [INSTR_W-1:0]  head_instr;
    logic [ADDR_W-1:0]   head_pc;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                is_jr_jalr;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign o_ready = !full;
    assign o_count = count_reg;

    // Full blocks pushes even when a pop happens the same cycle (no bypass).
    assign push = i_valid && !full;
    assign pop  = o_valid && !i_stall;

    assign {head_pc, head_instr} = mem[rd_ptr_reg];
    assign opcode     = head_instr[31:26];
    assign funct      = head_instr[5:0];
    assign is_jr_jalr = (opcode == OP_SPECIAL) && (funct == FN_JR || funct == FN_JALR);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Storage needs no reset: unoccupied entries are never presented.
    always_ff @(posedge clk) begin
        if (push && !i_flush) mem[wr_ptr_reg] <= {i_pc, i_instr};
    end

    always_comb begin
        o_instr     = '0;
        o_pc        = '0;
        o_rs_no     = '0;
        o_rt_no     = '0;
        o_is_branch = 1'b0;
        o_is_load   = 1'b0;
        if (!empty) begin
            o_instr = head_instr;
            o_pc    = head_pc;
            if (!(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI))
                o_rs_no = head_instr[25:21];
            // rt is only a source for R-type ALU ops, BEQ/BNE and stores.
            if ((opcode == OP_SPECIAL && !is_jr_jalr) || opcode == OP_BEQ || opcode == OP_BNE ||
                opcode == OP_SB || opcode == OP_SH || opcode == OP_SW)
                o_rt_no = head_instr[20:16];
            o_is_branch = is_jr_jalr || opcode == OP_REGIMM || opcode == OP_J || opcode == OP_JAL ||
                          opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_BLEZ ||
                          opcode == OP_BGTZ;
            o_is_load   = opcode == OP_LB || opcode == OP_LH || opcode == OP_LW ||
                          opcode == OP_LBU || opcode == OP_LHU;
        end
    end

    assign o_hazard = !empty && i_ex_load && (i_ex_rd_no != 5'd0) &&
                      (i_ex_rd_no == o_rs_no || i_ex_rd_no == o_rt_no);
    assign o_valid  = !empty && !o_hazard;

endmodule

// File: tb/tb_decode_iq.sv
// Bench for decode_iq: directed scenarios plus a randomized run against a queue-based model.
module tb_decode_iq;
    localparam int DEPTH = 4;

    logic        clk, nrst;
    logic        i_valid, o_ready, i_flush, i_stall, i_ex_load;
    logic [31:0] i_instr, i_pc, o_instr, o_pc;
    logic [4:0]  i_ex_rd_no, o_rs_no, o_rt_no;
    logic        o_valid, o_is_branch, o_is_load, o_hazard;
    logic [2:0]  o_count;

    int errors = 0;
    int checks = 0;
    logic [63:0] q[$];

    decode_iq #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32)) dut (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .i_stall(i_stall),
        .i_ex_load(i_ex_load), .i_ex_rd_no(i_ex_rd_no), .o_valid(o_valid),
        .o_instr(o_instr), .o_pc(o_pc), .o_rs_no(o_rs_no), .o_rt_no(o_rt_no),
        .o_is_branch(o_is_branch), .o_is_load(o_is_load), .o_hazard(o_hazard),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference predecode, taken straight from the MIPS-I field rules.
    function automatic logic [4:0] m_rs(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        return (op == 6'h02 || op == 6'h03 || op == 6'h0F) ? 5'd0 : ins[25:21];
    endfunction
    function automatic logic [4:0] m_rt(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        bit reads = (op == 6'h00 && fn != 6'h08 && fn != 6'h09) || op inside {6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        return reads ? ins[20:16] : 5'd0;
    endfunction
    function automatic logic m_br(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        return (op inside {[6'h01:6'h07]}) || (op == 6'h00 && ins[5:0] inside {6'h08, 6'h09});
    endfunction
    function automatic logic m_ld(input logic [31:0] ins);
        return ins[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction
    function automatic logic m_haz(input logic [31:0] ins, input bit nonempty, input logic ld, input logic [4:0] rd);
        return nonempty && ld && rd != 0 && (rd == m_rs(ins) || rd == m_rt(ins));
    endfunction

    task automatic idle();
        i_valid = 0; i_flush = 0; i_stall = 0; i_ex_load = 0; i_ex_rd_no = 0;
        i_instr = 0; i_pc = 0;
    endtask

    // One clock edge; the model applies the same transaction the inputs request.
    task automatic cycle();
        bit push, pop;
        logic [31:0] hi;
        hi   = (q.size() > 0) ? q[0][31:0] : 32'h0;
        push = i_valid && q.size() < DEPTH;
        pop  = q.size() > 0 && !m_haz(hi, 1'b1, i_ex_load, i_ex_rd_no) && !i_stall;
        @(posedge clk); #1;
        if (i_flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({i_pc, i_instr});
        end
        $display("cycle t=%0t count=%0d head_pc=%h", $time, o_count, o_pc);
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        i_valid = 1; i_pc = pc; i_instr = ins; i_stall = 1;
        cycle();
        i_valid = 0; i_stall = 0;
    endtask

    task automatic drain();
        idle(); i_flush = 1; cycle(); i_flush = 0;
    endtask

    task automatic test_reset();
        idle(); nrst = 0; #2;
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", o_count); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        checks++; if (o_valid !== 1'b0 || o_hazard !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b want=00", o_valid, o_hazard); end
        checks++; if (o_instr !== 0 || o_pc !== 0 || o_rs_no !== 0 || o_rt_no !== 0 || o_is_branch !== 0 || o_is_load !== 0) begin
            errors++; $display("FAIL reset_head got instr=%h pc=%h want 0", o_instr, o_pc); end
        @(posedge clk); #1; nrst = 1;
    endtask

    task automatic test_fill();
        idle(); i_stall = 1;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1; i_pc = 32'h100 + 32'(4 * k); i_instr = 32'h00001020 + 32'(k << 11);
            cycle();
            checks++; if (o_count !== 3'((k < 4) ? k + 1 : 4)) begin errors++; $display("FAIL fill_count k=%0d got=%0d", k, o_count); end
        end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", o_ready); end
        checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL fill_head got=%h want=100", o_pc); end
        idle();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (o_pc !== 32'h100 + 32'(4 * k) || o_valid !== 1'b1) begin
                errors++; $display("FAIL fill_drain k=%0d got pc=%h v=%b want pc=%h v=1", k, o_pc, o_valid, 32'h100 + 32'(4 * k)); end
            cycle();
        end
        checks++; if (o_count !== 0 || o_valid !== 0 || o_pc !== 0) begin errors++; $display("FAIL fill_empty got count=%0d v=%b pc=%h", o_count, o_valid, o_pc); end
    endtask

    task automatic test_stream();
        idle();
        push_one(32'h200, 32'h00430820);
        push_one(32'h204, 32'h00430820);
        for (int k = 0; k < 8; k++) begin
            i_valid = 1; i_pc = 32'h208 + 32'(4 * k); i_instr = 32'h00430820;
            #1;
            checks++; if (o_pc !== 32'h200 + 32'(4 * k) || o_valid !== 1'b1) begin
                errors++; $display("FAIL stream_head k=%0d got=%h want=%h", k, o_pc, 32'h200 + 32'(4 * k)); end
            cycle();
            checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL stream_count k=%0d got=%0d want=2", k, o_count); end
        end
        drain();
    endtask

    task automatic test_flush();
        idle();
        for (int k = 0; k < 3; k++) push_one(32'h500 + 32'(4 * k), 32'h00430820);
        i_valid = 1; i_pc = 32'h50C; i_instr = 32'h00430820; i_flush = 1;
        cycle(); idle();
        checks++; if (o_count !== 0 || o_valid !== 0 || o_instr !== 0 || o_ready !== 1) begin
            errors++; $display("FAIL flush got count=%0d v=%b instr=%h rdy=%b want 0 0 0 1", o_count, o_valid, o_instr, o_ready); end
    endtask

    task automatic test_hazard();
        idle();
        push_one(32'h300, 32'h00851020);
        i_ex_load = 1; i_ex_rd_no = 5; #1;
        checks++; if (o_hazard !== 1 || o_valid !== 0) begin errors++; $display("FAIL hazard_rt got h=%b v=%b want 1 0", o_hazard, o_valid); end
        cycle();
        checks++; if (o_count !== 1 || o_pc !== 32'h300) begin errors++; $display("FAIL hazard_hold got count=%0d pc=%h want 1 300", o_count, o_pc); end
        i_ex_rd_no = 4; #1;
        checks++; if (o_hazard !== 1) begin errors++; $display("FAIL hazard_rs got=%b want=1", o_hazard); end
        i_ex_rd_no = 2; #1;
        checks++; if (o_hazard !== 0 || o_valid !== 1) begin errors++; $display("FAIL hazard_rd got h=%b v=%b want 0 1", o_hazard, o_valid); end
        i_ex_rd_no = 5; i_ex_load = 0; #1;
        checks++; if (o_valid !== 1 || o_hazard !== 0) begin errors++; $display("FAIL hazard_drop got v=%b h=%b want 1 0", o_valid, o_hazard); end
        cycle();
        checks++; if (o_count !== 0) begin errors++; $display("FAIL hazard_pop got=%0d want=0", o_count); end
    endtask

    task automatic test_exempt();
        idle();
        push_one(32'h600, 32'h3CA61234);
        push_one(32'h604, 32'h00001020);
        i_ex_load = 1; i_ex_rd_no = 5; #1;
        checks++; if (o_rs_no !== 0 || o_rt_no !== 0 || o_hazard !== 0 || o_valid !== 1) begin
            errors++; $display("FAIL exempt_lui got rs=%0d rt=%0d h=%b v=%b want 0 0 0 1", o_rs_no, o_rt_no, o_hazard, o_valid); end
        cycle();
        i_ex_rd_no = 0; #1;
        checks++; if (o_pc !== 32'h604 || o_hazard !== 0 || o_valid !== 1) begin
            errors++; $display("FAIL exempt_r0 got pc=%h h=%b v=%b want 604 0 1", o_pc, o_hazard, o_valid); end
        drain();
    endtask

    task automatic test_reset_midop();
        idle();
        for (int k = 0; k < 3; k++) push_one(32'h700 + 32'(4 * k), 32'h00430820);
        #1; nrst = 0; #1;
        checks++; if (o_count !== 0 || o_valid !== 0 || o_ready !== 1) begin
            errors++; $display("FAIL async_reset got count=%0d v=%b rdy=%b want 0 0 1", o_count, o_valid, o_ready); end
        q.delete(); nrst = 1;
        push_one(32'h800, 32'h00430820);
        checks++; if (o_count !== 1 || o_pc !== 32'h800) begin errors++; $display("FAIL post_reset_push got count=%0d pc=%h want 1 800", o_count, o_pc); end
        drain();
    endtask

    task automatic test_predecode();
        idle();
        push_one(32'h400, 32'h03E00008);
        push_one(32'h404, 32'h8C880004);
        #1;
        checks++; if (o_is_branch !== 1 || o_rs_no !== 31 || o_rt_no !== 0 || o_is_load !== 0) begin
            errors++; $display("FAIL pd_jr got br=%b rs=%0d rt=%0d ld=%b want 1 31 0 0", o_is_branch, o_rs_no, o_rt_no, o_is_load); end
        cycle();
        checks++; if (o_is_load !== 1 || o_rs_no !== 4 || o_rt_no !== 0 || o_is_branch !== 0) begin
            errors++; $display("FAIL pd_lw got ld=%b rs=%0d rt=%0d br=%b want 1 4 0 0", o_is_load, o_rs_no, o_rt_no, o_is_branch); end
        drain();
    endtask

    task automatic test_random();
        logic [5:0]  ops [14] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                  6'h07, 6'h0F, 6'h20, 6'h23, 6'h25, 6'h2B};
        logic [5:0]  fns [4] = '{6'h08, 6'h09, 6'h20, 6'h2A};
        logic [31:0] r, hi;
        logic [63:0] h;
        bit ne;
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            r[31:26] = ops[$urandom_range(13)];
            if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(3)];
            i_instr = r; i_pc = $urandom;
            i_valid = ($urandom_range(9) < 7);
            i_stall = ($urandom_range(9) < 3);
            i_flush = ($urandom_range(39) == 0);
            i_ex_load = ($urandom_range(9) < 4);
            i_ex_rd_no = 5'($urandom_range(7));
            #1;
            ne = q.size() > 0;
            h  = ne ? q[0] : 64'h0;
            hi = h[31:0];
            checks++; if (o_count !== 3'(q.size()) || o_ready !== (q.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_count n=%0d got=%0d rdy=%b want=%0d", n, o_count, o_ready, q.size()); end
            checks++; if (o_instr !== hi || o_pc !== h[63:32]) begin
                errors++; $display("FAIL rnd_head n=%0d got %h/%h want %h/%h", n, o_pc, o_instr, h[63:32], hi); end
            checks++; if (o_rs_no !== m_rs(hi) || o_rt_no !== m_rt(hi) || o_is_branch !== (ne && m_br(hi)) || o_is_load !== (ne && m_ld(hi))) begin
                errors++; $display("FAIL rnd_predecode n=%0d instr=%h got rs=%0d rt=%0d br=%b ld=%b", n, hi, o_rs_no, o_rt_no, o_is_branch, o_is_load); end
            checks++; if (o_hazard !== m_haz(hi, ne, i_ex_load, i_ex_rd_no) || o_valid !== (ne && !m_haz(hi, ne, i_ex_load, i_ex_rd_no))) begin
                errors++; $display("FAIL rnd_hazard n=%0d got h=%b v=%b", n, o_hazard, o_valid); end
            cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_hazard();
        test_exempt();
        test_reset_midop();
        test_predecode();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
